// File: rtl/gcd_stream_harness.sv
// gcd_stream_harness
//   Val/rdy stimulus/response engine for the gcd chip. Reads operand pairs
//   from a sync-read input memory, presents them on the ops handshake, takes
//   results from the res handshake, writes each result to an output memory
//   port and caps the number of issued-but-unanswered transactions.
//
// Parameters
//   WL        operand/result width
//   N         transactions per run (1..2**CNT_W-1)
//   CNT_W     counter/address width
//   MAX_OUT   max outstanding transactions (1..255)
//   LFSR_SEED nonzero seed of the res_rdy stall LFSR
//
// Ports
//   clk, rst_b          clock (rising edge), async reset ACTIVE-HIGH
//   start               begin a run (honoured only in IDLE/DONE)
//   stall_en            gate res_rdy with the LFSR
//   mem_addr/mem_data   input memory, data valid one cycle after address
//   op_a/op_b/ops_val/ops_rdy   operand handshake to the chip
//   res/res_val/res_rdy         result handshake from the chip
//   out_we/out_addr/out_data    output memory write port
//   issued/recv         accepted operand pairs / accepted results
//   busy/done           run in progress / run complete
//
// Configuration
//   GCD_HARNESS_CHECK_EN: adds exp_data (in) and err_cnt (out); every accepted
//   result is compared against exp_data, mismatches counted (saturating).
module gcd_stream_harness #(
  parameter int             WL        = 8,
  parameter int             N         = 1024,
  parameter int             CNT_W     = 16,
  parameter int             MAX_OUT   = 4,
  parameter logic [7:0]     LFSR_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic              stall_en,
  output logic [CNT_W-1:0]  mem_addr,
  input  logic [2*WL-1:0]   mem_data,
  output logic [WL-1:0]     op_a,
  output logic [WL-1:0]     op_b,
  output logic              ops_val,
  input  logic              ops_rdy,
  input  logic [WL-1:0]     res,
  input  logic              res_val,
  output logic              res_rdy,
  output logic              out_we,
  output logic [CNT_W-1:0]  out_addr,
  output logic [WL-1:0]     out_data,
  output logic [CNT_W-1:0]  issued,
  output logic [CNT_W-1:0]  recv,
  output logic              busy,
  output logic              done
`ifdef GCD_HARNESS_CHECK_EN
  ,
  input  logic [WL-1:0]     exp_data,
  output logic [CNT_W-1:0]  err_cnt
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_PRESENT = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [CNT_W-1:0] N_C   = CNT_W'(N);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUT);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] recv_q, recv_d;
  logic [WL-1:0]    op_a_q, op_b_q;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [CNT_W-1:0] outstanding;
  logic             start_go, ops_fire, res_fire, busy_w, load_ops;

  assign busy_w   = (state_q == S_FETCH) || (state_q == S_PRESENT) || (state_q == S_WAIT);
  assign start_go = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign ops_fire = (state_q == S_PRESENT) && ops_rdy;
  // Never take more than N results, even if the chip sends extras before
  // the FSM reaches DONE.
  assign res_rdy  = busy_w && (recv_q != N_C) && (stall_en ? lfsr_q[0] : 1'b1);
  assign res_fire = res_val && res_rdy;

  assign outstanding = issued_q - recv_q;

  always_comb begin
    issued_d = issued_q;
    recv_d   = recv_q;
    if (start_go) begin
      issued_d = '0;
      recv_d   = '0;
    end else begin
      if (ops_fire) issued_d = issued_q + 1'b1;
      if (res_fire) recv_d   = recv_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_FETCH;
      // Throttle: stay in FETCH while the in-flight window is full.
      S_FETCH:        if (outstanding != MAX_C) state_d = S_PRESENT;
      S_PRESENT: begin
        if (ops_rdy) begin
          if (issued_d == N_C) state_d = (recv_d == N_C) ? S_DONE : S_WAIT;
          else                 state_d = S_FETCH;
        end
      end
      // Look at the next-state count so DONE is entered on the edge that
      // takes the last result; no window where a surplus result is taken.
      S_WAIT:         if (recv_d == N_C) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Operands are latched on the FETCH->PRESENT edge; memory data is valid
  // then because the address was already driven one cycle earlier.
  assign load_ops = (state_q == S_FETCH) && (state_d == S_PRESENT);

  // x^8+x^6+x^5+x^4+1, right-shifting Fibonacci form.
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[4], lfsr_q[7:1]};

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q  <= S_IDLE;
      issued_q <= '0;
      recv_q   <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      lfsr_q   <= LFSR_SEED;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      recv_q   <= recv_d;
      if (load_ops) begin
        op_a_q <= mem_data[2*WL-1:WL];
        op_b_q <= mem_data[WL-1:0];
      end
      if (busy_w) lfsr_q <= lfsr_d;
    end
  end

  // Address follows the next-state issue count so the sync-read memory
  // returns the pair during FETCH: 2-cycle issue rate.
  assign mem_addr = issued_d;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign ops_val  = (state_q == S_PRESENT);
  assign out_we   = res_fire;
  assign out_addr = recv_q;
  assign out_data = res_fire ? res : '0;
  assign issued   = issued_q;
  assign recv     = recv_q;
  assign busy     = busy_w;
  assign done     = (state_q == S_DONE);

`ifdef GCD_HARNESS_CHECK_EN
  logic [CNT_W-1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (start_go)                                          err_d = '0;
    else if (res_fire && (res != exp_data) && (err_q != '1)) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) err_q <= '0;
    else       err_q <= err_d;
  end

  assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_gcd_stream_harness.sv
// Bench for gcd_stream_harness: two instances (N=4/MAX_OUT=4 and
// N=16/MAX_OUT=2), each with a sync-read operand memory and a simple gcd
// chip model; results are compared against hand-computed tables.
module tb_gcd_stream_harness;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Operand table and hand-computed gcd results.
  logic [15:0] mem [0:31];
  logic [7:0]  exp_g [0:15];
  initial begin
    mem[0]  = {8'd12, 8'd8};   exp_g[0]  = 8'd4;
    mem[1]  = {8'd9, 8'd6};    exp_g[1]  = 8'd3;
    mem[2]  = {8'd7, 8'd5};    exp_g[2]  = 8'd1;
    mem[3]  = {8'd0, 8'd3};    exp_g[3]  = 8'd3;
    mem[4]  = {8'd10, 8'd4};   exp_g[4]  = 8'd2;
    mem[5]  = {8'd15, 8'd25};  exp_g[5]  = 8'd5;
    mem[6]  = {8'd21, 8'd14};  exp_g[6]  = 8'd7;
    mem[7]  = {8'd36, 8'd24};  exp_g[7]  = 8'd12;
    mem[8]  = {8'd17, 8'd17};  exp_g[8]  = 8'd17;
    mem[9]  = {8'd100, 8'd75}; exp_g[9]  = 8'd25;
    mem[10] = {8'd8, 8'd0};    exp_g[10] = 8'd8;
    mem[11] = {8'd49, 8'd35};  exp_g[11] = 8'd7;
    mem[12] = {8'd64, 8'd48};  exp_g[12] = 8'd16;
    mem[13] = {8'd27, 8'd18};  exp_g[13] = 8'd9;
    mem[14] = {8'd30, 8'd45};  exp_g[14] = 8'd15;
    mem[15] = {8'd11, 8'd22};  exp_g[15] = 8'd11;
    for (int i = 16; i < 32; i++) mem[i] = 16'h0101;
  end

  function automatic logic [7:0] gcd(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, t;
    a = a_in; b = b_in;
    for (int k = 0; k < 300 && b != 0; k++) begin
      t = a % b; a = b; b = t;
    end
    return a;
  endfunction

  function automatic logic [7:0] lfsr_nxt(input logic [7:0] m);
    logic fb;
    fb = ^(m & 8'h1D);
    return {fb, m[7:1]};
  endfunction

  // ---------------- instance A: N=4, MAX_OUT=4 ----------------
  logic        rst_a, start_a, stall_a, ops_rdy_a, res_val_a, ret_a;
  logic [7:0]  res_a, op_a_a, op_b_a, out_data_a;
  logic [15:0] mem_addr_a, mem_data_a, out_addr_a, issued_a, recv_a;
  logic        ops_val_a, res_rdy_a, out_we_a, busy_a, done_a;

  // ---------------- instance B: N=16, MAX_OUT=2 ---------------
  logic        rst_b, start_b, stall_b, ops_rdy_b, res_val_b, ret_b;
  logic [7:0]  res_b, op_a_b, op_b_b, out_data_b;
  logic [15:0] mem_addr_b, mem_data_b, out_addr_b, issued_b, recv_b;
  logic        ops_val_b, res_rdy_b, out_we_b, busy_b, done_b;

`ifdef GCD_HARNESS_CHECK_EN
  logic        corrupt_a = 1'b0;
  logic [7:0]  exp_a, exp_b;
  logic [15:0] err_a, err_b;
  assign exp_a = exp_g[out_addr_a[3:0]] ^ ((corrupt_a && out_addr_a == 16'd2) ? 8'hFF : 8'h00);
  assign exp_b = exp_g[out_addr_b[3:0]];
`endif

  gcd_stream_harness #(.WL(8), .N(4), .CNT_W(16), .MAX_OUT(4), .LFSR_SEED(8'hA5)) u_dut_a (
    .clk(clk), .rst_b(rst_a), .start(start_a), .stall_en(stall_a),
    .mem_addr(mem_addr_a), .mem_data(mem_data_a),
    .op_a(op_a_a), .op_b(op_b_a), .ops_val(ops_val_a), .ops_rdy(ops_rdy_a),
    .res(res_a), .res_val(res_val_a), .res_rdy(res_rdy_a),
    .out_we(out_we_a), .out_addr(out_addr_a), .out_data(out_data_a),
    .issued(issued_a), .recv(recv_a), .busy(busy_a), .done(done_a)
`ifdef GCD_HARNESS_CHECK_EN
    , .exp_data(exp_a), .err_cnt(err_a)
`endif
  );

  gcd_stream_harness #(.WL(8), .N(16), .CNT_W(16), .MAX_OUT(2), .LFSR_SEED(8'hA5)) u_dut_b (
    .clk(clk), .rst_b(rst_b), .start(start_b), .stall_en(stall_b),
    .mem_addr(mem_addr_b), .mem_data(mem_data_b),
    .op_a(op_a_b), .op_b(op_b_b), .ops_val(ops_val_b), .ops_rdy(ops_rdy_b),
    .res(res_b), .res_val(res_val_b), .res_rdy(res_rdy_b),
    .out_we(out_we_b), .out_addr(out_addr_b), .out_data(out_data_b),
    .issued(issued_b), .recv(recv_b), .busy(busy_b), .done(done_b)
`ifdef GCD_HARNESS_CHECK_EN
    , .exp_data(exp_b), .err_cnt(err_b)
`endif
  );

  // Sync-read operand memories.
  always @(posedge clk) mem_data_a <= mem[mem_addr_a[4:0]];
  always @(posedge clk) mem_data_b <= mem[mem_addr_b[4:0]];

  // Chip models: handshakes sampled mid-cycle, applied just after the edge.
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic fo_a, fr_a, fo_b, fr_b;
  logic [7:0] ca_a, cb_a, ca_b, cb_b;

  always begin
    @(negedge clk);
    fo_a = ops_val_a & ops_rdy_a; fr_a = res_val_a & res_rdy_a; ca_a = op_a_a; cb_a = op_b_a;
    @(posedge clk); #1;
    if (rst_a) q_a.delete();
    else begin
      if (fr_a && q_a.size() > 0) void'(q_a.pop_front());
      if (fo_a) q_a.push_back(gcd(ca_a, cb_a));
    end
    res_val_a = ret_a && (q_a.size() > 0);
    res_a     = (q_a.size() > 0) ? q_a[0] : 8'd0;
  end

  always begin
    @(negedge clk);
    fo_b = ops_val_b & ops_rdy_b; fr_b = res_val_b & res_rdy_b; ca_b = op_a_b; cb_b = op_b_b;
    @(posedge clk); #1;
    if (rst_b) q_b.delete();
    else begin
      if (fr_b && q_b.size() > 0) void'(q_b.pop_front());
      if (fo_b) q_b.push_back(gcd(ca_b, cb_b));
    end
    res_val_b = ret_b && (q_b.size() > 0);
    res_b     = (q_b.size() > 0) ? q_b[0] : 8'd0;
  end

  // Output-memory write logs.
  int la_addr[$], la_data[$], lb_addr[$], lb_data[$];
  always @(negedge clk) if (out_we_a) begin la_addr.push_back(int'(out_addr_a)); la_data.push_back(int'(out_data_a)); end
  always @(negedge clk) if (out_we_b) begin lb_addr.push_back(int'(out_addr_b)); lb_data.push_back(int'(out_data_b)); end

  task automatic clear_logs();
    la_addr.delete(); la_data.delete(); lb_addr.delete(); lb_data.delete();
  endtask

  task automatic pulse_start(input bit sel);
    @(posedge clk); #1;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = sel ? done_b : done_a;
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
  endtask

  task automatic check_log(input bit sel, input int n, input string tag);
    int sz;
    sz = sel ? lb_addr.size() : la_addr.size();
    chk({tag, "_wr_cnt"}, 32'(sz), 32'(n));
    for (int i = 0; i < n && i < sz; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(sel ? lb_addr[i] : la_addr[i]), 32'(i));
      chk($sformatf("%s_data%0d", tag, i), 32'(sel ? lb_data[i] : la_data[i]), 32'(exp_g[i]));
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m;
    int bad;
    bit hit;
    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0; stall_a = 1'b0; stall_b = 1'b0;
    ops_rdy_a = 1'b0; ops_rdy_b = 1'b0; ret_a = 1'b0; ret_b = 1'b0;
    res_val_a = 1'b0; res_val_b = 1'b0; res_a = 8'd0; res_b = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ops_val", 32'(ops_val_a), 32'd0);
    chk("rst_busy",    32'(busy_a),    32'd0);
    chk("rst_done",    32'(done_a),    32'd0);
    chk("rst_issued",  32'(issued_b),  32'd0);
    chk("rst_mem_addr",32'(mem_addr_b),32'd0);
    chk("rst_res_rdy", 32'(res_rdy_b), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Basic run, ideal chip, no stalls.
    ops_rdy_a = 1'b1; ret_a = 1'b1; clear_logs();
    pulse_start(1'b0);
    @(negedge clk);
    chk("t1_busy", 32'(busy_a), 32'd1);
    chk("t1_mem_addr0", 32'(mem_addr_a), 32'd0);
    wait_done(1'b0, 200, "t1");
    chk("t1_busy_end", 32'(busy_a), 32'd0);
    chk("t1_recv",   32'(recv_a),   32'd4);
    chk("t1_issued", 32'(issued_a), 32'd4);
    check_log(1'b0, 4, "t1");

    // Back-pressure: operands must stay stable while ops_rdy is low.
    ops_rdy_a = 1'b0; clear_logs();
    pulse_start(1'b0);
    chk("t2_done_clr", 32'(done_a), 32'd0);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      hit = ops_val_a;
    end
    chk("t2_present", 32'(hit), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("t2_val",    32'(ops_val_a), 32'd1);
      chk("t2_op_a",   32'(op_a_a),    32'd12);
      chk("t2_op_b",   32'(op_b_a),    32'd8);
      chk("t2_issued", 32'(issued_a),  32'd0);
    end
    ops_rdy_a = 1'b1;
    wait_done(1'b0, 200, "t2");
    check_log(1'b0, 4, "t2");
`ifdef GCD_HARNESS_CHECK_EN
    chk("t2_err_cnt", 32'(err_a), 32'd0);
    corrupt_a = 1'b1; clear_logs();
    pulse_start(1'b0);
    wait_done(1'b0, 200, "t2c");
    chk("t2c_err_cnt", 32'(err_a), 32'd1);
    corrupt_a = 1'b0;
`endif

    // Outstanding limit: chip never answers.
    ops_rdy_b = 1'b1; ret_b = 1'b0; clear_logs();
    pulse_start(1'b1);
    repeat (30) @(negedge clk);
    chk("t3_issued",   32'(issued_b),   32'd2);
    chk("t3_mem_addr", 32'(mem_addr_b), 32'd2);
    chk("t3_ops_val",  32'(ops_val_b),  32'd0);
    chk("t3_busy",     32'(busy_b),     32'd1);
    chk("t3_recv",     32'(recv_b),     32'd0);
    ret_b = 1'b1;
    wait_done(1'b1, 500, "t3");
    check_log(1'b1, 16, "t3");

    // LFSR-stalled sink from a fresh reset.
    @(negedge clk); rst_b = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_b = 1'b0;
    clear_logs(); stall_b = 1'b1; m = 8'hA5; bad = 0; hit = 1'b0;
    pulse_start(1'b1);
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      if (res_rdy_b !== (busy_b & m[0])) bad++;
      if (busy_b) m = lfsr_nxt(m);
      hit = done_b;
    end
    chk("t4_lfsr_mismatches", 32'(bad), 32'd0);
    chk("t4_done", 32'(hit), 32'd1);
    chk("t4_recv", 32'(recv_b), 32'd16);
    check_log(1'b1, 16, "t4");

    // Reset in the middle of a run.
    stall_b = 1'b0; clear_logs();
    pulse_start(1'b1);
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      hit = (issued_b == 16'd5);
    end
    chk("t5_reach5", 32'(hit), 32'd1);
    rst_b = 1'b1; #1;
    chk("t5_issued",   32'(issued_b),   32'd0);
    chk("t5_recv",     32'(recv_b),     32'd0);
    chk("t5_busy",     32'(busy_b),     32'd0);
    chk("t5_done",     32'(done_b),     32'd0);
    chk("t5_ops_val",  32'(ops_val_b),  32'd0);
    chk("t5_res_rdy",  32'(res_rdy_b),  32'd0);
    chk("t5_out_we",   32'(out_we_b),   32'd0);
    chk("t5_mem_addr", 32'(mem_addr_b), 32'd0);
    chk("t5_op_a",     32'(op_a_b),     32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_b = 1'b0; clear_logs();
    repeat (5) @(negedge clk);
    chk("t5_no_we", 32'(lb_addr.size()), 32'd0);
    @(posedge clk); #1; start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    @(negedge clk);
    chk("t5_restart_addr", 32'(mem_addr_b), 32'd0);
    chk("t5_restart_busy", 32'(busy_b),     32'd1);
    wait_done(1'b1, 500, "t5");
    check_log(1'b1, 16, "t5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
